// File: rtl/snake_body_collision_scanner_pkg.sv
// Shared types for the snake body collision scanner: the coordinate pair
// and the scanner state encoding.
package snake_pkg;

    localparam int COORD_W_DEFAULT = 10;

    typedef struct packed {
        logic [COORD_W_DEFAULT-1:0] x;
        logic [COORD_W_DEFAULT-1:0] y;
    } coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/snake_body_collision_scanner_cmp.sv
// Combinational coordinate-pair equality: eq is high when both x and y match.
module coord_eq_cmp #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic               eq
);

    assign eq = (ax == bx) && (ay == by);

endmodule

// File: rtl/snake_body_collision_scanner.sv
// Snake body segment list with a sequential, early-exit collision scanner:
// one segment compare per clock against a latched query coordinate.
module snake_body_collision_scanner
    import snake_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEFAULT,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 320,
    parameter int INIT_Y   = 240,
    parameter int SEG_STEP = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [COORD_W-1:0]           push_x,
    input  logic [COORD_W-1:0]           push_y,
    input  logic                         grow,
    input  logic                         query_valid,
    output logic                         query_ready,
    input  logic [COORD_W-1:0]           query_x,
    input  logic [COORD_W-1:0]           query_y,
    input  logic                         skip_head,
    output logic                         result_valid,
    output logic                         hit,
    output logic [$clog2(MAX_LEN)-1:0]   hit_index,
    output logic [$clog2(MAX_LEN+1)-1:0] length
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    scan_state_t        state;
    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];
    logic [IW-1:0]      idx;
    logic [COORD_W-1:0] qx;
    logic [COORD_W-1:0] qy;
    logic               push_fire;
    logic               query_fire;
    logic               seg_eq;
    logic               at_last;
    logic [LW-1:0]      len_next;

    function automatic logic [COORD_W-1:0] init_x(input int k);
        return (k < INIT_LEN) ? COORD_W'(INIT_X - k * SEG_STEP) : '0;
    endfunction

    function automatic logic [COORD_W-1:0] init_y(input int k);
        return (k < INIT_LEN) ? COORD_W'(INIT_Y) : '0;
    endfunction

    assign push_ready  = (state == IDLE);
    assign query_ready = (state == IDLE);
    assign push_fire   = push_valid && push_ready;
    assign query_fire  = query_valid && query_ready;
    assign at_last     = (LW'(idx) == length - LW'(1));

    // Length as it will be after this cycle's push; a query accepted in the
    // same cycle scans the post-push list, so its empty-range test uses this.
    always_comb begin
        len_next = length;
        if (push_fire && grow && (length < LW'(MAX_LEN))) begin
            len_next = length + LW'(1);
        end
    end

    coord_eq_cmp #(
        .COORD_W(COORD_W)
    ) u_cmp (
        .ax(seg_x[idx]),
        .ay(seg_y[idx]),
        .bx(qx),
        .by(qy),
        .eq(seg_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x[k] <= init_x(k);
                seg_y[k] <= init_y(k);
            end
            length <= LW'(INIT_LEN);
        end else if (clear) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x[k] <= init_x(k);
                seg_y[k] <= init_y(k);
            end
            length <= LW'(INIT_LEN);
        end else if (push_fire) begin
            for (int k = MAX_LEN - 1; k > 0; k--) begin
                seg_x[k] <= seg_x[k-1];
                seg_y[k] <= seg_y[k-1];
            end
            seg_x[0] <= push_x;
            seg_y[0] <= push_y;
            length   <= len_next;
        end
    end

    // Scan FSM: result_valid is raised on entry to DONE so it lasts exactly
    // the single DONE cycle; hit/hit_index persist until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            qx           <= '0;
            qy           <= '0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            hit_index    <= '0;
        end else if (clear) begin
            state        <= IDLE;
            idx          <= '0;
            qx           <= '0;
            qy           <= '0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            hit_index    <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (query_fire) begin
                        qx  <= query_x;
                        qy  <= query_y;
                        idx <= IW'(skip_head);
                        if (skip_head && (len_next == LW'(1))) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            hit          <= 1'b0;
                            hit_index    <= '0;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (seg_eq) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        hit          <= 1'b1;
                        hit_index    <= idx;
                    end else if (at_last) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        hit          <= 1'b0;
                        hit_index    <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_collision_scanner.sv
// Directed bench: a 32-entry instance for the main cases and a 4-entry instance
// with a single-segment reset body for saturation and the empty-range scan.
module tb_snake_body_collision_scanner;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       clear       = 1'b0;
    logic       push_valid  = 1'b0;
    logic       grow        = 1'b0;
    logic       query_valid = 1'b0;
    logic       skip_head   = 1'b0;
    logic [9:0] push_x      = '0;
    logic [9:0] push_y      = '0;
    logic [9:0] query_x     = '0;
    logic [9:0] query_y     = '0;

    logic       push_ready_b, query_ready_b, result_valid_b, hit_b;
    logic [4:0] hit_index_b;
    logic [5:0] length_b;
    logic       push_ready_s, query_ready_s, result_valid_s, hit_s;
    logic [1:0] hit_index_s;
    logic [2:0] length_s;

    bit         use_small = 1'b0;
    logic       obs_rv, obs_hit, obs_qr, obs_pr;
    logic [4:0] obs_idx;
    logic [5:0] obs_len;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    snake_body_collision_scanner dut_big (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready_b),
        .push_x(push_x), .push_y(push_y), .grow(grow),
        .query_valid(query_valid), .query_ready(query_ready_b),
        .query_x(query_x), .query_y(query_y), .skip_head(skip_head),
        .result_valid(result_valid_b), .hit(hit_b),
        .hit_index(hit_index_b), .length(length_b)
    );

    snake_body_collision_scanner #(
        .MAX_LEN(4),
        .INIT_LEN(1)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready_s),
        .push_x(push_x), .push_y(push_y), .grow(grow),
        .query_valid(query_valid), .query_ready(query_ready_s),
        .query_x(query_x), .query_y(query_y), .skip_head(skip_head),
        .result_valid(result_valid_s), .hit(hit_s),
        .hit_index(hit_index_s), .length(length_s)
    );

    always_comb begin
        if (use_small) begin
            obs_rv  = result_valid_s;
            obs_hit = hit_s;
            obs_qr  = query_ready_s;
            obs_pr  = push_ready_s;
            obs_idx = {3'b000, hit_index_s};
            obs_len = {3'b000, length_s};
        end else begin
            obs_rv  = result_valid_b;
            obs_hit = hit_b;
            obs_qr  = query_ready_b;
            obs_pr  = push_ready_b;
            obs_idx = hit_index_b;
            obs_len = length_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        clear       = 1'b0;
        push_valid  = 1'b0;
        grow        = 1'b0;
        query_valid = 1'b0;
        skip_head   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic pushHead(input logic [9:0] x, input logic [9:0] y, input logic g);
        push_valid = 1'b1;
        push_x     = x;
        push_y     = y;
        grow       = g;
        @(posedge clk); #1;
        push_valid = 1'b0;
        grow       = 1'b0;
    endtask

    // Issues one query (any push already set up goes in the same cycle), then
    // checks result fields, latency from the accept edge, busy window and pulse width.
    task automatic applyStimulus(input string tag, input logic [9:0] x, input logic [9:0] y,
                                 input logic skip, input logic exp_hit, input int exp_idx,
                                 input int exp_lat);
        int   lat;
        logic ready_seen;
        query_valid = 1'b1;
        query_x     = x;
        query_y     = y;
        skip_head   = skip;
        @(posedge clk); #1;
        query_valid = 1'b0;
        skip_head   = 1'b0;
        push_valid  = 1'b0;
        grow        = 1'b0;
        lat         = 1;
        ready_seen  = 1'b0;
        while (!obs_rv && lat < 200) begin
            ready_seen = ready_seen | obs_qr;
            @(posedge clk); #1;
            lat++;
        end
        ready_seen = ready_seen | obs_qr;
        checkOutput({tag, "_valid"}, 32'(obs_rv), 32'd1);
        checkOutput({tag, "_hit"}, 32'(obs_hit), 32'(exp_hit));
        checkOutput({tag, "_index"}, 32'(obs_idx), exp_idx);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_busy"}, 32'(ready_seen), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_one_pulse"}, 32'(obs_rv), 32'd0);
        checkOutput({tag, "_hold"}, 32'(obs_hit), 32'(exp_hit));
    endtask

    task automatic watchQuiet(input string tag, input int n);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (obs_rv) pulses++;
        end
        checkOutput(tag, pulses, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        // Reset state and the basic hit / miss on the reset body (320,310,300 @ y=240)
        use_small = 1'b0;
        doReset();
        checkOutput("rst_result_valid", 32'(obs_rv), 32'd0);
        checkOutput("rst_hit", 32'(obs_hit), 32'd0);
        checkOutput("rst_hit_index", 32'(obs_idx), 32'd0);
        checkOutput("rst_push_ready", 32'(obs_pr), 32'd1);
        checkOutput("rst_query_ready", 32'(obs_qr), 32'd1);
        checkOutput("rst_length", 32'(obs_len), 32'd3);
        applyStimulus("t1", 10'd300, 10'd240, 1'b0, 1'b1, 2, 4);
        checkOutput("t1_length", 32'(obs_len), 32'd3);
        applyStimulus("t2", 10'd0, 10'd0, 1'b0, 1'b0, 0, 4);

        // Grow then plain push: body becomes 340,330,320,310 and 300 falls off
        doReset();
        pushHead(10'd330, 10'd240, 1'b1);
        checkOutput("t3_len_grow", 32'(obs_len), 32'd4);
        pushHead(10'd340, 10'd240, 1'b0);
        checkOutput("t3_len_keep", 32'(obs_len), 32'd4);
        applyStimulus("t3_miss", 10'd290, 10'd240, 1'b0, 1'b0, 0, 5);
        applyStimulus("t3_last", 10'd310, 10'd240, 1'b0, 1'b1, 3, 5);
        applyStimulus("t3_tail", 10'd300, 10'd240, 1'b0, 1'b0, 0, 5);
        applyStimulus("t3_head", 10'd340, 10'd240, 1'b0, 1'b1, 0, 2);

        // Self-collision: body (320,240),(330,230),(320,230),(320,240),(310,240),(300,240)
        doReset();
        pushHead(10'd320, 10'd230, 1'b1);
        pushHead(10'd330, 10'd230, 1'b1);
        pushHead(10'd320, 10'd240, 1'b1);
        checkOutput("t4_length", 32'(obs_len), 32'd6);
        applyStimulus("t4_self", 10'd320, 10'd240, 1'b1, 1'b1, 3, 4);
        applyStimulus("t4_noskip", 10'd320, 10'd240, 1'b0, 1'b1, 0, 2);
        applyStimulus("t4_first", 10'd330, 10'd230, 1'b1, 1'b1, 1, 2);

        // Small instance: single-segment body (320,240), unused entries hold (0,0)
        use_small = 1'b1;
        doReset();
        checkOutput("t4s_length", 32'(obs_len), 32'd1);
        applyStimulus("t4s_empty", 10'd320, 10'd240, 1'b1, 1'b0, 0, 1);
        applyStimulus("t4s_single", 10'd320, 10'd240, 1'b0, 1'b1, 0, 2);
        applyStimulus("t4s_beyond", 10'd0, 10'd0, 1'b0, 1'b0, 0, 2);
        push_valid = 1'b1;
        push_x     = 10'd5;
        push_y     = 10'd5;
        grow       = 1'b1;
        applyStimulus("t4s_same_cycle", 10'd320, 10'd240, 1'b1, 1'b1, 1, 2);
        checkOutput("t4s_same_len", 32'(obs_len), 32'd2);

        // Saturation: six growing pushes leave (6,6),(5,5),(4,4),(3,3)
        doReset();
        for (int k = 1; k <= 6; k++) begin
            pushHead(10'(k), 10'(k), 1'b1);
        end
        checkOutput("t5_length_sat", 32'(obs_len), 32'd4);
        applyStimulus("t5_oldest", 10'd3, 10'd3, 1'b0, 1'b1, 3, 5);
        applyStimulus("t5_dropped", 10'd2, 10'd2, 1'b0, 1'b0, 0, 5);
        applyStimulus("t5_init", 10'd320, 10'd240, 1'b0, 1'b0, 0, 5);
        query_valid = 1'b1;
        query_x     = 10'd9;
        query_y     = 10'd9;
        @(posedge clk); #1;
        query_valid = 1'b0;
        push_valid  = 1'b1;
        push_x      = 10'd7;
        push_y      = 10'd7;
        grow        = 1'b1;
        checkOutput("t5_push_ready_busy", 32'(obs_pr), 32'd0);
        @(posedge clk); #1;
        push_valid = 1'b0;
        grow       = 1'b0;
        n = 0;
        while (!obs_rv && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("t5_scan_done", 32'(obs_rv), 32'd1);
        checkOutput("t5_scan_hit", 32'(obs_hit), 32'd0);
        @(posedge clk); #1;
        checkOutput("t5_len_ignored", 32'(obs_len), 32'd4);
        applyStimulus("t5_ignored", 10'd7, 10'd7, 1'b0, 1'b0, 0, 5);
        applyStimulus("t5_head", 10'd6, 10'd6, 1'b0, 1'b1, 0, 2);

        // Asynchronous reset in the middle of a scan
        use_small = 1'b0;
        doReset();
        pushHead(10'd330, 10'd240, 1'b1);
        applyStimulus("t6_pre", 10'd320, 10'd240, 1'b0, 1'b1, 1, 3);
        query_valid = 1'b1;
        query_x     = 10'd0;
        query_y     = 10'd0;
        @(posedge clk); #1;
        query_valid = 1'b0;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(obs_rv), 32'd0);
        checkOutput("t6_rst_hit", 32'(obs_hit), 32'd0);
        checkOutput("t6_rst_index", 32'(obs_idx), 32'd0);
        checkOutput("t6_rst_query_ready", 32'(obs_qr), 32'd1);
        checkOutput("t6_rst_push_ready", 32'(obs_pr), 32'd1);
        checkOutput("t6_rst_length", 32'(obs_len), 32'd3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        watchQuiet("t6_rst_no_pulse", 8);
        applyStimulus("t6_rst_list", 10'd330, 10'd240, 1'b0, 1'b0, 0, 4);
        applyStimulus("t6_rst_tail", 10'd300, 10'd240, 1'b0, 1'b1, 2, 4);

        // Synchronous clear in the middle of a scan
        pushHead(10'd330, 10'd240, 1'b1);
        applyStimulus("t6_pre_clr", 10'd310, 10'd240, 1'b0, 1'b1, 2, 4);
        query_valid = 1'b1;
        query_x     = 10'd0;
        query_y     = 10'd0;
        @(posedge clk); #1;
        query_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checkOutput("t6_clr_valid", 32'(obs_rv), 32'd0);
        checkOutput("t6_clr_query_ready", 32'(obs_qr), 32'd1);
        checkOutput("t6_clr_length", 32'(obs_len), 32'd3);
        watchQuiet("t6_clr_no_pulse", 8);
        applyStimulus("t6_clr_list", 10'd330, 10'd240, 1'b0, 1'b0, 0, 4);
        applyStimulus("t6_clr_head", 10'd320, 10'd240, 1'b0, 1'b1, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
